uart_tx_fifo: RTL

Buffered serial transmitter for the byte output port of the picorv32 system. It sits directly downstream of the system's out_byte/out_byte_en strobe. It queues each strobed byte in a small FIFO and shifts it out on a single txd line as 8N1 frames (8 data bits, no parity, 1 stop bit). There is no backpressure: the producer never stalls, and overflow is reported through a sticky flag.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/tx_byte_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the buffered UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after DATA).
package uart_tx_pkg;

   localparam int DATA_BITS = 8;
   localparam int TIMER_W   = 16;
   localparam int BIT_IDX_W = $clog2(DATA_BITS);

   // PARITY is only reachable when UART_TX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: synchronous show-ahead byte FIFO with full/empty/level.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Optional feature macro: UART_TX_PARITY_EN (not used in this file).
module tx_byte_fifo
   import uart_tx_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         wr_en,
   input  logic [DATA_BITS-1:0]         wr_data,
   input  logic                         rd_en,
   output logic [DATA_BITS-1:0]         rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 w_wr_ok;
   logic                 w_rd_ok;
   logic [AW:0]          w_diff;

   // A write into a full FIFO is legal only when a read frees a slot this cycle.
   assign w_rd_ok = rd_en & ~empty;
   assign w_wr_ok = wr_en & (~full | w_rd_ok);

   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
   assign w_diff  = r_wr_ptr - r_rd_ptr;
   assign level   = LW'(w_diff);
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array write port.
   // NOTE: the data array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Read/write pointers, wrapping modulo 2*DEPTH.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a registered-output 8N1 serial transmitter.
// Producer never stalls; dropped writes raise a sticky overflow flag.
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit, 8E1).
module uart_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int CLK_DIV = 434,
   parameter int DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [DATA_BITS-1:0]         in_data,
   input  logic                         in_valid,
   input  logic                         clr_overflow,
   output logic                         txd,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow
);

   localparam logic [TIMER_W-1:0]   C_RELOAD   = TIMER_W'(CLK_DIV - 1);
   localparam logic [BIT_IDX_W-1:0] C_LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   tx_state_t              r_state;
   logic [TIMER_W-1:0]     r_timer;
   logic [BIT_IDX_W-1:0]   r_bit_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_txd;
   logic                   r_overflow;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity;
`endif

   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_bit_end;
   logic [DATA_BITS-1:0]   w_rd_data;

   // Pop from IDLE, or on the last STOP cycle so back-to-back frames have no gap.
   assign w_bit_end = (r_timer == '0);
   assign w_pop     = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
   assign w_push    = in_valid & (~w_full | w_pop);
   assign w_drop    = in_valid & ~w_push;

   assign txd      = r_txd;
   assign overflow = r_overflow;
   assign busy     = (r_state != IDLE) | ~w_empty;

   tx_byte_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (w_push),
      .wr_data (in_data),
      .rd_en   (w_pop),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .level   (level)
   );

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   // Transmit FSM with bit timer, shift register and registered txd.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_rd_data;
                  r_state <= START;
                  r_timer <= C_RELOAD;
                  r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_rd_data;
`endif
               end
            end

            START: begin
               if (w_bit_end) begin
                  r_state   <= DATA;
                  r_timer   <= C_RELOAD;
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
               end else begin
                  r_timer <= r_timer - TIMER_W'(1);
               end
            end

            DATA: begin
               if (w_bit_end) begin
                  r_timer <= C_RELOAD;
                  if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     // LSB first: shift right and present the next bit.
                     r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                     r_shift   <= r_shift >> 1;
                     r_txd     <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer - TIMER_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_state <= STOP;
                  r_timer <= C_RELOAD;
                  r_txd   <= 1'b1;
               end else begin
                  r_timer <= r_timer - TIMER_W'(1);
               end
            end
`endif

            STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift <= w_rd_data;
                     r_state <= START;
                     r_timer <= C_RELOAD;
                     r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_rd_data;
`endif
                  end else begin
                     r_state <= IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer - TIMER_W'(1);
               end
            end

            default: begin
               r_state <= IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
